pe_mac_pipe: RTL and testbench

PE_MAC_PIPE -- requirements
Module: pe_mac_pipe

---
 rtl/pe_pkg.sv | 48 ++++
 rtl/pe_mac_pipe_wq.sv | 78 +++++++
 rtl/pe_mac_pipe.sv | 132 +++++++++++++
 tb/tb_pe_mac_pipe.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared defaults, status bits and Q-format helpers for the MAC processing element
//
// Purpose: one place for the default fixed-point geometry, the status-bit
// positions and the rounding/wrapping/saturation arithmetic used in stage 2.
// The helpers work on 64-bit signed values, so any DATA_W up to 32 fits.
// Ports: none (package).

package pe_pkg;

    localparam int PE_DATA_W = 16;
    localparam int PE_FRAC_W = 8;

    // Bit positions inside the sticky status register
    localparam int STAT_OVF = 0;
    localparam int STAT_ERR = 1;
    localparam int STAT_W   = 2;

    // Round half up, then drop frac_w fractional bits (arithmetic shift)
    function automatic logic signed [63:0] q_round_shr(input logic signed [63:0] v, input int frac_w);
        logic signed [63:0] bias;
        bias = (frac_w == 0) ? 64'sd0 : (64'sd1 <<< (frac_w - 1));
        return (v + bias) >>> frac_w;
    endfunction

    // Keep the low w bits and sign-extend them back to 64 bits
    function automatic logic signed [63:0] q_wrap(input logic signed [63:0] v, input int w);
        return (v <<< (64 - w)) >>> (64 - w);
    endfunction

    function automatic logic q_in_range(input logic signed [63:0] v, input int w);
        logic signed [63:0] lim;
        lim = 64'sd1 <<< (w - 1);
        return (v >= -lim) && (v <= lim - 64'sd1);
    endfunction

    function automatic logic signed [63:0] q_sat(input logic signed [63:0] v, input int w);
        logic signed [63:0] lim;
        lim = 64'sd1 <<< (w - 1);
        if (v > lim - 64'sd1) begin
            return lim - 64'sd1;
        end
        if (v < -lim) begin
            return -lim;
        end
        return v;
    endfunction

endpackage

// File: rtl/pe_mac_pipe_wq.sv
// rtl/pe_mac_pipe_wq.sv - weight queue: circular buffer with wrapping pointers and a level counter
//
// Purpose: FIFO of pending weights feeding the active-weight register.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   en             global enable; all state frozen when low
//   push, wdata    enqueue request and data
//   pop            dequeue request (switch)
//   head           current head entry
//   pop_ok         pop request that will take effect this cycle
//   err            pop on empty, or push dropped on full with no pop
//   level          registered occupancy 0..DEPTH

module pe_wq #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       push,
    input  logic [DATA_W-1:0]          wdata,
    input  logic                       pop,
    output logic [DATA_W-1:0]          head,
    output logic                       pop_ok,
    output logic                       err,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic              full;
    logic              empty;
    logic              push_ok;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        full    = (level == LVL_W'(DEPTH));
        empty   = (level == '0);
        pop_ok  = pop && !empty;
        // A full queue still takes a push when the same cycle frees a slot
        push_ok = push && (!full || pop_ok);
        err     = (pop && empty) || (push && !push_ok);
        head    = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (en) begin
            if (push_ok) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (push_ok && !pop_ok) begin
                level <= level + LVL_W'(1);
            end else if (pop_ok && !push_ok) begin
                level <= level - LVL_W'(1);
            end
        end
    end

endmodule

// File: rtl/pe_mac_pipe.sv
// rtl/pe_mac_pipe.sv - two-stage fixed-point MAC processing element with a queued weight
//
// Purpose: psum_out = sat/wrap(round(input * active_weight) + psum_in), 2 cycles latency.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   pe_enabled                       global enable; freezes every register when low
//   pe_valid_in, pe_input_in,
//   pe_psum_in                       operand beat (west activation, north psum)
//   pe_accept_w_in, pe_weight_in     weight push into the queue
//   pe_switch_in                     pop queue head into the active weight
//   pe_valid_out, pe_psum_out        result beat
//   pe_input_out                     activation forwarded east
//   pe_accept_w_out, pe_weight_out   weight forwarded south
//   pe_wq_level_out                  queue occupancy
//   pe_ovf_out, pe_err_out           sticky overflow / queue-misuse flags

module pe_mac_pipe
    import pe_pkg::*;
#(
    parameter int DATA_W   = PE_DATA_W,
    parameter int FRAC_W   = PE_FRAC_W,
    parameter int WQ_DEPTH = 2,
    parameter int SAT_EN   = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pe_enabled,
    input  logic                          pe_valid_in,
    input  logic [DATA_W-1:0]             pe_input_in,
    input  logic [DATA_W-1:0]             pe_psum_in,
    input  logic                          pe_accept_w_in,
    input  logic [DATA_W-1:0]             pe_weight_in,
    input  logic                          pe_switch_in,
    output logic                          pe_valid_out,
    output logic [DATA_W-1:0]             pe_psum_out,
    output logic [DATA_W-1:0]             pe_input_out,
    output logic                          pe_accept_w_out,
    output logic [DATA_W-1:0]             pe_weight_out,
    output logic [$clog2(WQ_DEPTH+1)-1:0] pe_wq_level_out,
    output logic                          pe_ovf_out,
    output logic                          pe_err_out
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = DATA_W + 2;

    logic [DATA_W-1:0]        wq_head;
    logic                     wq_pop_ok;
    logic                     wq_err;

    logic signed [DATA_W-1:0] active_w;
    logic                     s1_valid;
    logic signed [PROD_W-1:0] s1_prod;
    logic signed [DATA_W-1:0] s1_psum;

    logic signed [63:0]       s2_sum;
    logic                     s2_ovf;
    logic [DATA_W-1:0]        s2_res;
    logic [STAT_W-1:0]        status;

    pe_wq #(
        .DATA_W (DATA_W),
        .DEPTH  (WQ_DEPTH)
    ) u_wq (
        .clk    (clk),
        .rst    (rst),
        .en     (pe_enabled),
        .push   (pe_accept_w_in),
        .wdata  (pe_weight_in),
        .pop    (pe_switch_in),
        .head   (wq_head),
        .pop_ok (wq_pop_ok),
        .err    (wq_err),
        .level  (pe_wq_level_out)
    );

    // Stage 2: rounded product and psum are summed in DATA_W+2 bits, so the
    // rounded product is wrapped to that width before and after the add.
    always_comb begin
        s2_sum = q_wrap(q_wrap(q_round_shr(64'(s1_prod), FRAC_W), SUM_W) + 64'(s1_psum), SUM_W);
        s2_ovf = !q_in_range(s2_sum, DATA_W);
        s2_res = DATA_W'((SAT_EN != 0) ? q_sat(s2_sum, DATA_W) : s2_sum);
    end

    assign pe_ovf_out = status[STAT_OVF];
    assign pe_err_out = status[STAT_ERR];

    always_ff @(posedge clk) begin
        if (rst) begin
            active_w        <= '0;
            s1_valid        <= 1'b0;
            s1_prod         <= '0;
            s1_psum         <= '0;
            pe_valid_out    <= 1'b0;
            pe_psum_out     <= '0;
            pe_input_out    <= '0;
            pe_accept_w_out <= 1'b0;
            pe_weight_out   <= '0;
            status          <= '0;
        end else if (pe_enabled) begin
            pe_accept_w_out <= pe_accept_w_in;
            if (pe_accept_w_in) begin
                pe_weight_out <= pe_weight_in;
            end

            // The product below still sees the pre-switch active weight
            if (wq_pop_ok) begin
                active_w <= wq_head;
            end

            if (pe_valid_in) begin
                pe_input_out <= pe_input_in;
                s1_prod      <= PROD_W'($signed(pe_input_in)) * PROD_W'(active_w);
                s1_psum      <= pe_psum_in;
            end
            s1_valid <= pe_valid_in;

            pe_valid_out <= s1_valid;
            if (s1_valid) begin
                pe_psum_out <= s2_res;
                if (s2_ovf) begin
                    status[STAT_OVF] <= 1'b1;
                end
            end

            if (wq_err) begin
                status[STAT_ERR] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pe_mac_pipe.sv
// tb/tb_pe_mac_pipe.sv - self-checking bench for pe_mac_pipe (Q8.8, 2-entry queue, saturating and wrapping builds)

module tb_pe_mac_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        pe_enabled;
    logic        pe_valid_in;
    logic [15:0] pe_input_in;
    logic [15:0] pe_psum_in;
    logic        pe_accept_w_in;
    logic [15:0] pe_weight_in;
    logic        pe_switch_in;

    logic        pe_valid_out;
    logic [15:0] pe_psum_out;
    logic [15:0] pe_input_out;
    logic        pe_accept_w_out;
    logic [15:0] pe_weight_out;
    logic [1:0]  pe_wq_level_out;
    logic        pe_ovf_out;
    logic        pe_err_out;

    logic        w_valid_out;
    logic [15:0] w_psum_out;
    logic [15:0] w_input_out;
    logic        w_accept_w_out;
    logic [15:0] w_weight_out;
    logic [1:0]  w_wq_level_out;
    logic        w_ovf_out;
    logic        w_err_out;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pe_mac_pipe #(.DATA_W(16), .FRAC_W(8), .WQ_DEPTH(2), .SAT_EN(1)) dut (
        .clk(clk), .rst(rst), .pe_enabled(pe_enabled), .pe_valid_in(pe_valid_in),
        .pe_input_in(pe_input_in), .pe_psum_in(pe_psum_in), .pe_accept_w_in(pe_accept_w_in),
        .pe_weight_in(pe_weight_in), .pe_switch_in(pe_switch_in),
        .pe_valid_out(pe_valid_out), .pe_psum_out(pe_psum_out), .pe_input_out(pe_input_out),
        .pe_accept_w_out(pe_accept_w_out), .pe_weight_out(pe_weight_out),
        .pe_wq_level_out(pe_wq_level_out), .pe_ovf_out(pe_ovf_out), .pe_err_out(pe_err_out)
    );

    pe_mac_pipe #(.DATA_W(16), .FRAC_W(8), .WQ_DEPTH(2), .SAT_EN(0)) dut_wrap (
        .clk(clk), .rst(rst), .pe_enabled(pe_enabled), .pe_valid_in(pe_valid_in),
        .pe_input_in(pe_input_in), .pe_psum_in(pe_psum_in), .pe_accept_w_in(pe_accept_w_in),
        .pe_weight_in(pe_weight_in), .pe_switch_in(pe_switch_in),
        .pe_valid_out(w_valid_out), .pe_psum_out(w_psum_out), .pe_input_out(w_input_out),
        .pe_accept_w_out(w_accept_w_out), .pe_weight_out(w_weight_out),
        .pe_wq_level_out(w_wq_level_out), .pe_ovf_out(w_ovf_out), .pe_err_out(w_err_out)
    );

    // Reference model state (saturating build)
    int          wq[$];
    int          m_active;
    bit          m_s1_v;
    logic [15:0] m_s1_res;
    bit          m_s1_ovf;
    bit          e_valid;
    logic [15:0] e_psum;
    logic [15:0] e_in;
    bit          e_acc;
    logic [15:0] e_w;
    bit          e_ovf;
    bit          e_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic longint wrap18(input longint v);
        longint m;
        m = v & 64'h3FFFF;
        if (m >= 131072) m = m - 262144;
        return m;
    endfunction

    // x, w, p are plain integers holding Q8.8 raw values
    function automatic logic [15:0] ref_mac(input int x, input int w, input int p, input bit sat, output bit ovf);
        longint prod;
        longint s;
        prod = longint'(x) * longint'(w);
        s = wrap18((prod + 128) >>> 8);
        s = wrap18(s + longint'(p));
        ovf = (s > 32767) || (s < -32768);
        if (sat && s > 32767) s = 32767;
        if (sat && s < -32768) s = -32768;
        return s[15:0];
    endfunction

    task automatic model_step();
        bit pop_ok;
        bit push_ok;
        if (rst) begin
            wq.delete();
            m_active = 0; m_s1_v = 0; m_s1_res = 0; m_s1_ovf = 0;
            e_valid = 0; e_psum = 0; e_in = 0; e_acc = 0; e_w = 0; e_ovf = 0; e_err = 0;
        end else if (pe_enabled) begin
            e_valid = m_s1_v;
            if (m_s1_v) begin
                e_psum = m_s1_res;
                if (m_s1_ovf) e_ovf = 1;
            end
            m_s1_v = pe_valid_in;
            if (pe_valid_in) begin
                m_s1_res = ref_mac(int'($signed(pe_input_in)), m_active, int'($signed(pe_psum_in)), 1'b1, m_s1_ovf);
                e_in = pe_input_in;
            end
            e_acc = pe_accept_w_in;
            if (pe_accept_w_in) e_w = pe_weight_in;
            pop_ok  = pe_switch_in && (wq.size() > 0);
            push_ok = pe_accept_w_in && ((wq.size() < 2) || pop_ok);
            if ((pe_switch_in && wq.size() == 0) || (pe_accept_w_in && !push_ok)) e_err = 1;
            if (pop_ok) m_active = wq.pop_front();
            if (push_ok) wq.push_back(int'($signed(pe_weight_in)));
        end
    endtask

    task automatic check_all();
        chk("valid_out", pe_valid_out, e_valid);
        chk("psum_out", pe_psum_out, e_psum);
        chk("input_out", pe_input_out, e_in);
        chk("accept_w_out", pe_accept_w_out, e_acc);
        chk("weight_out", pe_weight_out, e_w);
        chk("wq_level", pe_wq_level_out, wq.size());
        chk("ovf", pe_ovf_out, e_ovf);
        chk("err", pe_err_out, e_err);
        chk("wrap_valid_out", w_valid_out, e_valid);
        chk("wrap_input_out", w_input_out, e_in);
        chk("wrap_accept_w_out", w_accept_w_out, e_acc);
        chk("wrap_weight_out", w_weight_out, e_w);
        chk("wrap_wq_level", w_wq_level_out, wq.size());
        chk("wrap_err", w_err_out, e_err);
    endtask

    task automatic cycle(input bit en, input bit r, input bit v, input logic [15:0] x,
                         input logic [15:0] p, input bit acc, input logic [15:0] w, input bit sw);
        rst = r; pe_enabled = en; pe_valid_in = v; pe_input_in = x; pe_psum_in = p;
        pe_accept_w_in = acc; pe_weight_in = w; pe_switch_in = sw;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle();           cycle(1, 0, 0, 16'h0, 16'h0, 0, 16'h0, 0); endtask
    task automatic reset_cycle();    cycle(1, 1, 0, 16'h0, 16'h0, 0, 16'h0, 0); endtask
    task automatic push(input logic [15:0] w); cycle(1, 0, 0, 16'h0, 16'h0, 1, w, 0); endtask
    task automatic do_switch();      cycle(1, 0, 0, 16'h0, 16'h0, 0, 16'h0, 1); endtask
    task automatic mac(input logic [15:0] x, input logic [15:0] p); cycle(1, 0, 1, x, p, 0, 16'h0, 0); endtask

    function automatic logic [15:0] rnd_q();
        if ($urandom_range(0, 3) == 0) return 16'($urandom);
        return 16'($urandom_range(0, 16'h0800)) - 16'h0400;
    endfunction

    initial begin
        rst = 1; pe_enabled = 0; pe_valid_in = 0; pe_input_in = 0; pe_psum_in = 0;
        pe_accept_w_in = 0; pe_weight_in = 0; pe_switch_in = 0;

        // Reset state, even with enable low
        cycle(0, 1, 0, 16'h0, 16'h0, 0, 16'h0, 0);
        reset_cycle();
        chk("rst_psum", pe_psum_out, 16'h0000);
        chk("rst_level", pe_wq_level_out, 2'd0);

        // 4.34765625 * 2.0 + 0
        push(16'h0459); do_switch(); mac(16'h0200, 16'h0000); idle();
        chk("mac1_psum", pe_psum_out, 16'h08B2);
        chk("mac1_valid", pe_valid_out, 1'b1);

        // 10.6015625 * -3.3984375 + 0, round toward +inf on the half
        push(16'h0A9A); do_switch(); mac(16'hFC9A, 16'h0000); idle();
        chk("mac2_psum", pe_psum_out, 16'hDBF9);
        chk("mac2_ovf", pe_ovf_out, 1'b0);

        // 127.0 * 2.0 saturates (and wraps in the SAT_EN=0 build)
        push(16'h7F00); do_switch(); mac(16'h0200, 16'h0000); idle();
        chk("sat_psum", pe_psum_out, 16'h7FFF);
        chk("sat_ovf", pe_ovf_out, 1'b1);
        chk("wrap_psum", w_psum_out, 16'hFE00);
        chk("wrap_ovf", w_ovf_out, 1'b1);
        mac(16'h0100, 16'h0100); idle(); idle();
        chk("ovf_sticky", pe_ovf_out, 1'b1);

        // Queue overflow, then drain with switches
        reset_cycle();
        chk("ovf_cleared", pe_ovf_out, 1'b0);
        push(16'h0100); push(16'h0200); push(16'h0300);
        chk("q3_level", pe_wq_level_out, 2'd2);
        chk("q3_err", pe_err_out, 1'b1);
        do_switch(); mac(16'h0100, 16'h0000); idle();
        chk("sw1_active", pe_psum_out, 16'h0100);
        do_switch(); mac(16'h0100, 16'h0000); idle();
        chk("sw2_active", pe_psum_out, 16'h0200);
        do_switch(); mac(16'h0100, 16'h0000); idle();
        chk("sw3_ignored", pe_psum_out, 16'h0200);
        chk("sw3_level", pe_wq_level_out, 2'd0);

        // Full queue with simultaneous push and switch, then a frozen window
        reset_cycle();
        push(16'h0111); push(16'h0222);
        cycle(1, 0, 0, 16'h0, 16'h0, 1, 16'h0333, 1);
        chk("fullsw_level", pe_wq_level_out, 2'd2);
        chk("fullsw_err", pe_err_out, 1'b0);
        mac(16'h0100, 16'h0010);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 1'($urandom), rnd_q(), rnd_q(), 1'($urandom), rnd_q(), 1'($urandom));
        end
        chk("freeze_level", pe_wq_level_out, 2'd2);
        idle();
        chk("unfreeze_psum", pe_psum_out, 16'h0121);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 7) != 0, $urandom_range(0, 63) == 0, 1'($urandom), rnd_q(), rnd_q(),
                  $urandom_range(0, 2) == 0, rnd_q(), $urandom_range(0, 2) == 0);
        end

        // Reset with two products in flight and both flags set
        reset_cycle();
        push(16'h7F00); do_switch(); do_switch();
        mac(16'h0200, 16'h0000); mac(16'h0200, 16'h0000); idle();
        chk("pre_rst_ovf", pe_ovf_out, 1'b1);
        chk("pre_rst_err", pe_err_out, 1'b1);
        push(16'h0100); mac(16'h0200, 16'h0000); mac(16'h0200, 16'h0000);
        reset_cycle();
        chk("midrst_valid", pe_valid_out, 1'b0);
        chk("midrst_psum", pe_psum_out, 16'h0000);
        chk("midrst_level", pe_wq_level_out, 2'd0);
        chk("midrst_ovf", pe_ovf_out, 1'b0);
        chk("midrst_err", pe_err_out, 1'b0);
        idle();
        chk("midrst_valid2", pe_valid_out, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
